usd_apu_cmd_bridge: RTL and testbench

USD_APU_CMD_BRIDGE -- requirements
Module: usd_apu_cmd_bridge

---
 rtl/usd_apu_cmd_bridge.sv | 134 +++++++++++++
 tb/tb_usd_apu_cmd_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usd_apu_cmd_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : usd_apu_cmd_bridge                                         |
// | Description : Issues one SD command word into a command FIFO, then waits |
// |               for and captures the matching result word, with timeout.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module usd_apu_cmd_bridge #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
   input  logic        apuClk,
   input  logic        sysRstN,
   input  logic        start,
   input  logic        abort,
   input  logic [5:0]  cmdIndex,
   input  logic [31:0] cmdArg,
   input  logic        dataPhase,
   input  logic [7:0]  cmdTag,
   input  logic        cmdRdyRd,
   input  logic        resultPending,
   input  logic [35:0] resultFifoData,
   output logic [71:0] cmdFifoData,
   output logic        cmdFifoWrEn,
   output logic        resultFifoRdEn,
   output logic        busy,
   output logic        done,
   output logic [31:0] respData,
   output logic [3:0]  respStatus,
   output logic        timeout
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE    = 3'd1,
      S_WAIT_RES = 3'd2,
      S_READ_RES = 3'd3,
      S_CAPTURE  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t      state_q,       state_d;
   logic [23:0] wait_cnt_q,    wait_cnt_d;
   logic [71:0] cmd_word_q,    cmd_word_d;
   logic [31:0] resp_data_q,   resp_data_d;
   logic [3:0]  resp_status_q, resp_status_d;
   logic        timeout_q,     timeout_d;

   always_ff @(posedge apuClk or negedge sysRstN) begin
      if (!sysRstN) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= 24'd0;
         cmd_word_q    <= 72'd0;
         resp_data_q   <= 32'd0;
         resp_status_q <= 4'd0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         cmd_word_q    <= cmd_word_d;
         resp_data_q   <= resp_data_d;
         resp_status_q <= resp_status_d;
         timeout_q     <= timeout_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = 24'd0;
      cmd_word_d     = cmd_word_q;
      resp_data_d    = resp_data_q;
      resp_status_d  = resp_status_q;
      timeout_d      = timeout_q;
      cmdFifoWrEn    = 1'b0;
      resultFifoRdEn = 1'b0;
      done           = 1'b0;

      // Abort wins over everything and leaves the captured response untouched.
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  cmd_word_d = {cmdTag, cmdIndex, 8'd0, dataPhase, 17'd0, cmdArg};
                  timeout_d  = 1'b0;
                  state_d    = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmdRdyRd) begin
                  cmdFifoWrEn = 1'b1;
                  state_d     = S_WAIT_RES;
               end
            end
            S_WAIT_RES: begin
               wait_cnt_d = wait_cnt_q + 24'd1;
               // A result on the final count is taken, not timed out.
               if (!resultPending) begin
                  resultFifoRdEn = 1'b1;
                  state_d        = S_READ_RES;
               end else if (wait_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
                  timeout_d     = 1'b1;
                  resp_status_d = 4'hF;
                  state_d       = S_DONE;
               end
            end
            S_READ_RES: begin
               state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
               resp_data_d   = resultFifoData[31:0];
               resp_status_d = resultFifoData[35:32];
               state_d       = S_DONE;
            end
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign cmdFifoData = cmd_word_q;
   assign respData    = resp_data_q;
   assign respStatus  = resp_status_q;
   assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_usd_apu_cmd_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_usd_apu_cmd_bridge                                      |
// | Description : Scoreboard bench for usd_apu_cmd_bridge (TIMEOUT_CYCLES=16)|
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_usd_apu_cmd_bridge;

   logic        apuClk = 1'b0;
   logic        sysRstN = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [5:0]  cmdIndex = 6'd0;
   logic [31:0] cmdArg = 32'd0;
   logic        dataPhase = 1'b0;
   logic [7:0]  cmdTag = 8'd0;
   logic        cmdRdyRd = 1'b0;
   logic        resultPending = 1'b1;
   logic [35:0] resultFifoData = 36'hBADBADBAD;
   logic [71:0] cmdFifoData;
   logic        cmdFifoWrEn;
   logic        resultFifoRdEn;
   logic        busy;
   logic        done;
   logic [31:0] respData;
   logic [3:0]  respStatus;
   logic        timeout;

   usd_apu_cmd_bridge #(.TIMEOUT_CYCLES(24'd16)) dut (
      .apuClk         (apuClk),
      .sysRstN        (sysRstN),
      .start          (start),
      .abort          (abort),
      .cmdIndex       (cmdIndex),
      .cmdArg         (cmdArg),
      .dataPhase      (dataPhase),
      .cmdTag         (cmdTag),
      .cmdRdyRd       (cmdRdyRd),
      .resultPending  (resultPending),
      .resultFifoData (resultFifoData),
      .cmdFifoData    (cmdFifoData),
      .cmdFifoWrEn    (cmdFifoWrEn),
      .resultFifoRdEn (resultFifoRdEn),
      .busy           (busy),
      .done           (done),
      .respData       (respData),
      .respStatus     (respStatus),
      .timeout        (timeout)
   );

   always #5 apuClk = ~apuClk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  status;
      logic        tmo;
      int          lat;
   } resp_t;

   resp_t       resp_q[$];
   logic [71:0] cmd_q[$];
   logic [35:0] fifo_word = 36'd0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          done_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge apuClk) cyc <= cyc + 1;

   // Non-FWFT result FIFO: the word appears after the edge that samples rd_en.
   always @(posedge apuClk) if (resultFifoRdEn) resultFifoData <= fifo_word;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge apuClk) begin
      if (sysRstN) begin
         if (cmdFifoWrEn && resultFifoRdEn) chk("strobe_overlap", 72'd1, 72'd0);
         if (cmdFifoWrEn) begin
            wr_cnt++;
            if (cmd_q.size() == 0) chk("unexpected_wr", 72'd1, 72'd0);
            else chk("cmd_word", cmdFifoData, cmd_q.pop_front());
         end
         if (resultFifoRdEn) rd_cnt++;
         if (done) begin
            resp_t e;
            done_cnt++;
            if (resp_q.size() == 0) chk("unexpected_done", 72'd1, 72'd0);
            else begin
               e = resp_q.pop_front();
               chk("resp_data", 72'(respData), 72'(e.data));
               chk("resp_status", 72'(respStatus), 72'(e.status));
               chk("timeout_flag", 72'(timeout), 72'(e.tmo));
               chk("latency", 72'(cyc - start_cyc), 72'(e.lat));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge apuClk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] tag, input logic [5:0] idx,
                           input logic [31:0] arg, input logic dp);
      cmdTag = tag; cmdIndex = idx; cmdArg = arg; dataPhase = dp;
      start = 1'b1;
      start_cyc = cyc;
      tick(1);
      start = 1'b0;
   endtask

   task automatic push_resp(input logic [31:0] d, input logic [3:0] s,
                            input logic t, input int lat);
      resp_t e;
      e.data = d; e.status = s; e.tmo = t; e.lat = lat;
      resp_q.push_back(e);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      if (busy) chk("idle_timeout", 72'd1, 72'd0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_cmdFifoData"}, cmdFifoData, 72'd0);
      chk({tag, "_wrEn"}, 72'(cmdFifoWrEn), 72'd0);
      chk({tag, "_rdEn"}, 72'(resultFifoRdEn), 72'd0);
      chk({tag, "_busy"}, 72'(busy), 72'd0);
      chk({tag, "_done"}, 72'(done), 72'd0);
      chk({tag, "_respData"}, 72'(respData), 72'd0);
      chk({tag, "_respStatus"}, 72'(respStatus), 72'd0);
      chk({tag, "_timeout"}, 72'(timeout), 72'd0);
   endtask

   initial begin
      int w0, r0, d0, bad;

      #3 chk_zero_outputs("reset");
      tick(2);
      sysRstN = 1'b1;
      tick(4);
      chk("post_reset_busy", 72'(busy), 72'd0);
      chk("post_reset_wr", 72'(wr_cnt), 72'd0);

      // Basic command: result arrives 10 cycles after start.
      w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
      cmdRdyRd = 1'b1; resultPending = 1'b1;
      fifo_word = 36'h3000001AA;
      cmd_q.push_back(72'h5A_20000000_000001AA);
      push_resp(32'h000001AA, 4'h3, 1'b0, 13);
      do_start(8'h5A, 6'd8, 32'h000001AA, 1'b0);
      tick(9);
      resultPending = 1'b0;
      tick(1);
      resultPending = 1'b1;
      wait_idle(40);
      chk("basic_wr_once", 72'(wr_cnt - w0), 72'd1);
      chk("basic_rd_once", 72'(rd_cnt - r0), 72'd1);
      chk("basic_done_once", 72'(done_cnt - d0), 72'd1);
      chk("basic_word_held", cmdFifoData, 72'h5A_20000000_000001AA);

      // Fastest path with max index and data phase set.
      fifo_word = 36'h912345678;
      resultPending = 1'b0;
      cmd_q.push_back(72'hA5_FC020000_DEADBEEF);
      push_resp(32'h12345678, 4'h9, 1'b0, 5);
      do_start(8'hA5, 6'd63, 32'hDEADBEEF, 1'b1);
      tick(2);
      resultPending = 1'b1;
      wait_idle(40);

      // Backpressure: command FIFO full for 50 cycles.
      w0 = wr_cnt; bad = 0;
      cmdRdyRd = 1'b0;
      fifo_word = 36'h700000042;
      cmd_q.push_back(72'h01_04000000_00000000);
      push_resp(32'h00000042, 4'h7, 1'b0, 54);
      do_start(8'h01, 6'd1, 32'h0, 1'b0);
      for (int i = 0; i < 49; i++) begin
         if (!busy || cmdFifoWrEn) bad++;
         tick(1);
      end
      chk("bp_busy_no_wr", 72'(bad), 72'd0);
      chk("bp_wr_held", 72'(wr_cnt - w0), 72'd0);
      cmdRdyRd = 1'b1; resultPending = 1'b0;
      tick(2);
      resultPending = 1'b1;
      wait_idle(40);
      chk("bp_wr_once", 72'(wr_cnt - w0), 72'd1);

      // Timeout: result never arrives.
      r0 = rd_cnt;
      cmd_q.push_back(72'h02_08000000_00000000);
      push_resp(32'h00000042, 4'hF, 1'b1, 18);
      do_start(8'h02, 6'd2, 32'h0, 1'b0);
      wait_idle(60);
      chk("tmo_no_rd", 72'(rd_cnt - r0), 72'd0);
      tick(3);
      chk("tmo_held", 72'(timeout), 72'd1);

      // Result exactly on the last count is taken.
      r0 = rd_cnt;
      fifo_word = 36'h2CAFEF00D;
      cmd_q.push_back(72'h03_0C000000_00000000);
      push_resp(32'hCAFEF00D, 4'h2, 1'b0, 20);
      do_start(8'h03, 6'd3, 32'h0, 1'b0);
      chk("tmo_cleared_on_start", 72'(timeout), 72'd0);
      tick(16);
      resultPending = 1'b0;
      tick(1);
      resultPending = 1'b1;
      wait_idle(40);
      chk("bound_rd_once", 72'(rd_cnt - r0), 72'd1);

      // Abort in WAIT_RES, then start+abort together in IDLE.
      r0 = rd_cnt; d0 = done_cnt;
      cmd_q.push_back(72'h04_10000000_00000055);
      do_start(8'h04, 6'd4, 32'h55, 1'b0);
      tick(2);
      abort = 1'b1; resultPending = 1'b0;
      tick(1);
      abort = 1'b0; resultPending = 1'b1;
      chk("abort_idle", 72'(busy), 72'd0);
      abort = 1'b1;
      do_start(8'h77, 6'd7, 32'h77, 1'b1);
      abort = 1'b0;
      chk("abort_start_ignored", 72'(busy), 72'd0);
      chk("abort_word_kept", cmdFifoData, 72'h04_10000000_00000055);
      tick(3);
      chk("abort_no_rd", 72'(rd_cnt - r0), 72'd0);
      chk("abort_no_done", 72'(done_cnt - d0), 72'd0);
      chk("abort_resp_kept", 72'(respData), 72'hCAFEF00D);

      // Reset asserted while a write strobe is high in ISSUE.
      w0 = wr_cnt;
      cmdRdyRd = 1'b0;
      do_start(8'h11, 6'd5, 32'h1234, 1'b0);
      cmdRdyRd = 1'b1;
      #1 chk("issue_wr_high", 72'(cmdFifoWrEn), 72'd1);
      sysRstN = 1'b0;
      #1 chk_zero_outputs("midreset");
      cmdRdyRd = 1'b0;
      tick(2);
      sysRstN = 1'b1;
      tick(4);
      chk("midreset_idle", 72'(busy), 72'd0);
      chk("midreset_no_wr", 72'(wr_cnt - w0), 72'd0);

      chk("total_wr", 72'(wr_cnt), 72'd6);
      chk("total_rd", 72'(rd_cnt), 72'd4);
      chk("total_done", 72'(done_cnt), 72'd5);
      chk("cmd_q_drained", 72'(cmd_q.size()), 72'd0);
      chk("resp_q_drained", 72'(resp_q.size()), 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
